seq_det_prog: RTL and testbench

//   Programmable, parametrised serial pattern detector; next generation of the fixed 1011 detector.

---
 rtl/seq_det_prog.sv | 100 ++++++++++
 tb/tb_seq_det_prog.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector with run-time pattern reload and overlap control.
// Define SEQDET_CNT_EN to build the saturating match counter; otherwise det_cnt_o is tied to 0.
module seq_det_prog #(
    parameter int unsigned    N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter int unsigned    CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inp_i,
    input  logic             in_valid_i,
    input  logic             overlap_i,
    input  logic             pat_load_i,
    input  logic [N-1:0]     pat_in_i,
    output logic [N-1:0]     pattern_o,
    output logic             det_o,
    output logic [CNT_W-1:0] det_cnt_o
);

    localparam int unsigned FillW = (N > 2) ? $clog2(N) : 1;
    localparam logic [FillW-1:0] FillLast = FillW'(N - 2);

    typedef enum logic {StFill, StArmed} state_e;

    state_e           state_q;
    logic [N-1:0]     pattern_q;
    // Only the newest N-1 bits can ever take part in a future match.
    logic [N-2:0]     sr_q;
    logic [FillW-1:0] fill_q;
    logic             det_q;

    logic             accept;
    logic [N-1:0]     window;
    logic             match;

    always_comb begin
        accept = in_valid_i & ~pat_load_i;
        window = {sr_q, inp_i};
        match  = accept && (state_q == StArmed) && (window == pattern_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pattern_q <= PATTERN;
            sr_q      <= '0;
            fill_q    <= '0;
            state_q   <= StFill;
            det_q     <= 1'b0;
        end else if (pat_load_i) begin
            pattern_q <= pat_in_i;
            sr_q      <= '0;
            fill_q    <= '0;
            state_q   <= StFill;
            det_q     <= 1'b0;
        end else begin
            det_q <= match;
            if (in_valid_i) begin
                unique case (state_q)
                    StFill: begin
                        sr_q   <= window[N-2:0];
                        fill_q <= fill_q + FillW'(1);
                        if (fill_q == FillLast) begin
                            state_q <= StArmed;
                        end
                    end
                    StArmed: begin
                        if (match && !overlap_i) begin
                            sr_q    <= '0;
                            fill_q  <= '0;
                            state_q <= StFill;
                        end else begin
                            sr_q <= window[N-2:0];
                        end
                    end
                    default: state_q <= StFill;
                endcase
            end
        end
    end

    assign pattern_o = pattern_q;
    assign det_o     = det_q;

`ifdef SEQDET_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign det_cnt_o = cnt_q;
`else
    assign det_cnt_o = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Scoreboard bench for seq_det_prog: a default instance and a CNT_W=2 instance share stimulus.
module tb_seq_det_prog;

    logic       clk;
    logic       rst;
    logic       inp;
    logic       in_valid;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic [3:0] pattern;
    logic [3:0] pattern_s;
    logic       det;
    logic       det_s;
    logic [7:0] det_cnt;
    logic [1:0] det_cnt_s;

    seq_det_prog dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .inp_i      (inp),
        .in_valid_i (in_valid),
        .overlap_i  (overlap),
        .pat_load_i (pat_load),
        .pat_in_i   (pat_in),
        .pattern_o  (pattern),
        .det_o      (det),
        .det_cnt_o  (det_cnt)
    );

    seq_det_prog #(.CNT_W(2)) dut_sat (
        .clk_i      (clk),
        .rst_i      (rst),
        .inp_i      (inp),
        .in_valid_i (in_valid),
        .overlap_i  (overlap),
        .pat_load_i (pat_load),
        .pat_in_i   (pat_in),
        .pattern_o  (pattern_s),
        .det_o      (det_s),
        .det_cnt_o  (det_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       det;
        logic [3:0] pat;
        int         cnt;
        int         cnt_sat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          pulses;

    // Reference model: full accepted-bit history since the last clear.
    logic [31:0] m_hist;
    int          m_len;
    logic [3:0]  m_pat;
    int          m_cnt;
    int          m_cnt_sat;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int c);
`ifdef SEQDET_CNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic model_reset();
        m_hist    = '0;
        m_len     = 0;
        m_pat     = 4'b1011;
        m_cnt     = 0;
        m_cnt_sat = 0;
    endtask

    // Drive one cycle, push the model's prediction, then compare after the edge.
    task automatic cycle(input logic v, input logic b, input logic ld, input logic [3:0] pi,
                         input logic ov, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        in_valid = v;
        inp      = b;
        pat_load = ld;
        pat_in   = pi;
        overlap  = ov;
        e.det    = 1'b0;
        if (ld) begin
            m_pat  = pi;
            m_hist = '0;
            m_len  = 0;
        end else if (v) begin
            m_hist = {m_hist[30:0], b};
            m_len++;
            if (m_len >= 4 && m_hist[3:0] == m_pat) begin
                e.det = 1'b1;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_cnt_sat = (m_cnt_sat < 3) ? m_cnt_sat + 1 : 3;
                if (!ov) m_len = 0;
            end
        end
        e.pat     = m_pat;
        e.cnt     = exp_cnt(m_cnt);
        e.cnt_sat = exp_cnt(m_cnt_sat);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_eq({tag, ".det"}, 32'(det), 32'(got.det));
        check_eq({tag, ".det_sat"}, 32'(det_s), 32'(got.det));
        check_eq({tag, ".pattern"}, 32'(pattern), 32'(got.pat));
        check_eq({tag, ".cnt"}, 32'(det_cnt), 32'(got.cnt));
        check_eq({tag, ".cnt_sat"}, 32'(det_cnt_s), 32'(got.cnt_sat));
        if (det) pulses++;
        in_valid = 1'b0;
        pat_load = 1'b0;
    endtask

    logic [20:0] stream;
    logic [6:0]  stream5;

    initial begin
        rst      = 1'b1;
        inp      = 1'b0;
        in_valid = 1'b0;
        overlap  = 1'b1;
        pat_load = 1'b0;
        pat_in   = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.det", 32'(det), 32'd0);
        check_eq("rst.cnt", 32'(det_cnt), 32'd0);
        check_eq("rst.pattern", 32'(pattern), 32'hB);
        @(negedge clk);
        rst = 1'b0;

        // Stream bit i sits at stream[20-i].
        stream = 21'b001101011101101100011;

        pulses = 0;
        for (int i = 0; i < 21; i++) cycle(1'b1, stream[20-i], 1'b0, 4'h0, 1'b1, "ovl");
        check_eq("ovl.pulses", 32'(pulses), 32'd3);

        cycle(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, "reload1");
        pulses = 0;
        for (int i = 0; i < 21; i++) cycle(1'b1, stream[20-i], 1'b0, 4'h0, 1'b0, "novl");
        check_eq("novl.pulses", 32'(pulses), 32'd2);

        cycle(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, "reload2");
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, (i == 1) ? 1'b0 : 1'b1, 1'b0, 4'h0, 1'b1, "gap.bit");
            repeat (2) cycle(1'b0, 1'($urandom_range(1)), 1'b0, 4'h0, 1'b1, "gap.stall");
        end
        check_eq("gap.pulses", 32'(pulses), 32'd1);

        cycle(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, "load.pre");
        cycle(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, "load.pre");
        cycle(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, "load.pre");
        cycle(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, "load");
        stream5 = 7'b0110110;
        pulses  = 0;
        for (int i = 0; i < 7; i++) cycle(1'b1, stream5[6-i], 1'b0, 4'h0, 1'b1, "newpat");
        check_eq("newpat.pulses", 32'(pulses), 32'd2);
        check_eq("newpat.det_live", 32'(det), 32'd1);

        // Asynchronous reset mid-cycle while det is high and a loaded pattern is active.
        #1;
        rst = 1'b1;
        #1;
        check_eq("arst.det", 32'(det), 32'd0);
        check_eq("arst.cnt", 32'(det_cnt), 32'd0);
        check_eq("arst.cnt_sat", 32'(det_cnt_s), 32'd0);
        check_eq("arst.pattern", 32'(pattern), 32'hB);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        pulses = 0;
        for (int i = 0; i < 4; i++) cycle(1'b1, (i == 1) ? 1'b0 : 1'b1, 1'b0, 4'h0, 1'b1, "post");
        check_eq("post.pulses", 32'(pulses), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "post.idle");
        check_eq("sb.empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
